ls_load_unit: RTL and testbench
===============================

LS_LOAD_UNIT -- requirements
Module: ls_load_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles allowed before a memory read is abandoned (legal range 1-255).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a load; sampled only in IDLE.
REQ-005 addr  input  32  SHALL be the load byte address, latched on accepted start.
REQ-006 LS_control  input  2  SHALL select the load size: 00 none, 01 LB, 10 LH, 11 LW; latched on accepted start.
REQ-007 unsigned_ld  input  1  SHALL select extension (1 zero-extend, 0 sign-extend); latched on accepted start.
REQ-008 mem_rd  output  1  SHALL be the memory read request.
REQ-009 mem_addr  output  32  SHALL be the latched address presented to memory.
REQ-010 mem_rd_ack  input  1  SHALL indicate that mem_rdata is valid this cycle.
REQ-011 mem_rdata  input  32  SHALL be the memory read word.
REQ-012 Data_out  output  32  SHALL be the registered, extended load result.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done  output  1  SHALL be a one-cycle completion pulse.
REQ-015 err  output  1  SHALL be a one-cycle timeout pulse.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE, ERR.
REQ-017 IDLE, start=1, LS_control!=00 -> WAIT SHALL latch addr, LS_control and unsigned_ld and clear the wait counter.
REQ-018 IDLE, start=1, LS_control=00 -> DONE SHALL set Data_out to 0 and SHALL not assert mem_rd.
REQ-019 In WAIT, mem_rd SHALL be 1 and mem_addr SHALL equal the latched address; mem_rd SHALL be 0 in every other state.
REQ-020 In WAIT with mem_rd_ack=1, the FSM SHALL go to DONE and load Data_out from mem_rdata in the same edge.
REQ-021 LB SHALL produce {24 x ext, mem_rdata[7:0]}, with ext = unsigned_ld ? 0 : mem_rdata[7].
REQ-022 LH SHALL produce {16 x ext, mem_rdata[15:0]}, with ext = unsigned_ld ? 0 : mem_rdata[15].
REQ-023 LW SHALL produce mem_rdata unchanged; unsigned_ld is ignored.
REQ-024 Byte lane SHALL always be the low-order bits, matching the store-merge lane convention; addr[1:0] SHALL not shift the lane.
REQ-025 In WAIT without ack, the 8-bit counter SHALL increment each cycle; when the counter equals TIMEOUT-1 and no ack arrives, the FSM SHALL go to ERR.
REQ-026 Ack in the same cycle as the timeout condition SHALL take priority: go to DONE, not ERR.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-028 ERR SHALL assert err=1 for exactly one cycle, leave Data_out unchanged, then go to IDLE.
REQ-029 start while busy SHALL be ignored and not queued; mem_rd_ack outside WAIT SHALL be ignored.
REQ-030 Latency: start accepted at edge N -> mem_rd high from cycle N+1; ack sampled at edge M -> done high during cycle M+1; minimum start-to-done = 2 edges.
REQ-031 done and err SHALL never be high together.
REQ-032 Data_out SHALL hold its value between completions.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, with mem_rd=0, mem_addr=0, Data_out=0, busy=0, done=0, err=0, and counter=0.
REQ-034 Reset asserted in WAIT SHALL abort the load, and a later ack SHALL have no effect.

Verification
REQ-035 LB signed: addr=0x10, rdata=0x123456F0, ack after 3 cycles -> mem_rd high for 3 cycles, then Data_out=0xFFFFFFF0 and done pulse.
REQ-036 LH unsigned: rdata=0xAAAA8001, unsigned_ld=1 -> Data_out=0x00008001; with LW -> Data_out=0xAAAA8001.
REQ-037 Timeout: TIMEOUT=4, no ack -> mem_rd high for 4 cycles, then err pulse, Data_out unchanged, and busy low after.
REQ-038 Ack in the final timeout cycle -> done=1, err stays 0, Data_out updated.
REQ-039 LS_control=00 start -> no mem_rd, Data_out=0, done pulse after 1 edge; a second start during WAIT is ignored.
REQ-040 reset_n low mid-WAIT, then ack -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/ls_load_unit.sv
// Load unit: issues one memory read per accepted start, waits for the ack with a timeout,
// and registers the size-selected, sign/zero-extended result.
module ls_load_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  LS_control,
    input  logic        unsigned_ld,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Data_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // state  | meaning
    // IDLE   | waiting for start
    // WAIT   | read outstanding, counting cycles until ack or timeout
    // DONE   | one-cycle completion pulse, Data_out just updated
    // ERR    | one-cycle timeout pulse, Data_out untouched
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [7:0]  cnt_q, cnt_d;

    // Lane is always the low-order bits; the address offset never shifts it.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz, input logic u);
        logic [31:0] r;
        case (sz)
            2'b01:   r = {{24{~u & w[7]}}, w[7:0]};
            2'b10:   r = {{16{~u & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        mem_rd  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (LS_control == 2'b00) begin
                        data_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr;
                        size_d  = LS_control;
                        uns_d   = unsigned_ld;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_rd = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem_rd_ack) begin
                    data_d  = extend(mem_rdata, size_q, uns_q);
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign Data_out = data_q;

endmodule

// File: tb/tb_ls_load_unit.sv
// Bench for ls_load_unit: directed literal scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model.
module tb_ls_load_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  ls = '0;
    logic        uns = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        mem_rd, busy, done, err;
    logic [31:0] mem_addr, Data_out;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    ls_load_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .LS_control(ls),
        .unsigned_ld(uns), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rd_ack(ack),
        .mem_rdata(rdata), .Data_out(Data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding load, tracked as "read in flight" plus cycles waited.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] sz, input bit u);
        int v;
        case (sz)
            2'b01: begin
                v = int'(w[7:0]);
                if (!u && v >= 128) v = v - 256;
                return 32'(v);
            end
            2'b10: begin
                v = int'(w[15:0]);
                if (!u && v >= 32768) v = v - 65536;
                return 32'(v);
            end
            default: return w;
        endcase
    endfunction

    bit          m_wait = 0, m_done = 0, m_err = 0;
    int          m_waited = 0;
    logic [31:0] m_data = '0, m_addr = '0;
    logic [1:0]  m_size = '0;
    bit          m_uns = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_wait <= 0; m_done <= 0; m_err <= 0; m_waited <= 0;
            m_data <= '0; m_addr <= '0;
        end else if (m_done || m_err) begin
            m_done <= 0; m_err <= 0;
        end else if (m_wait) begin
            if (ack) begin
                m_data <= ref_ext(rdata, m_size, m_uns);
                m_wait <= 0; m_done <= 1;
            end else if (m_waited + 1 == TO) begin
                m_wait <= 0; m_err <= 1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (start) begin
            if (ls == 2'b00) begin
                m_data <= '0; m_done <= 1;
            end else begin
                m_wait <= 1; m_waited <= 0; m_addr <= addr; m_size <= ls; m_uns <= uns;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_rd", 32'(mem_rd), 32'(m_wait));
            chk("busy", 32'(busy), 32'(m_wait | m_done | m_err));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("done_err_excl", 32'(done & err), 32'd0);
            chk("Data_out", Data_out, m_data);
            if (m_wait) chk("mem_addr", mem_addr, m_addr);
        end
    end

    task automatic do_load(input logic [1:0] l, input bit u, input logic [31:0] a,
                           input logic [31:0] rd, input int ack_at,
                           output int rd_cyc, output bit saw_done, output bit saw_err,
                           output logic [31:0] dout, output int done_cyc);
        rd_cyc = 0; saw_done = 0; saw_err = 0; dout = '0; done_cyc = 0;
        start = 1; ls = l; uns = u; addr = a; rdata = rd;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 0; ack = 0;
            if (mem_rd) rd_cyc++;
            if (done) begin saw_done = 1; dout = Data_out; done_cyc = i; end
            if (err) begin saw_err = 1; dout = Data_out; end
            if ((saw_done || saw_err) && !busy) break;
            if (mem_rd && rd_cyc == ack_at) ack = 1;
        end
        chk("load_completes", 32'(saw_done | saw_err), 32'd1);
    endtask

    int          rc, dc;
    bit          sd, se;
    logic [31:0] dv;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_Data_out", Data_out, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset_n = 1;
        cmp_en = 1;
        @(negedge clk);

        do_load(2'b01, 0, 32'h10, 32'h123456F0, 3, rc, sd, se, dv, dc);
        chk("lb_rd_cycles", 32'(rc), 3);
        chk("lb_done", 32'(sd), 1);
        chk("lb_err", 32'(se), 0);
        chk("lb_data", dv, 32'hFFFFFFF0);
        chk("lb_latency", 32'(dc), 4);

        do_load(2'b10, 1, 32'h22, 32'hAAAA8001, 1, rc, sd, se, dv, dc);
        chk("lhu_data", dv, 32'h00008001);
        do_load(2'b10, 0, 32'h22, 32'hAAAA8001, 2, rc, sd, se, dv, dc);
        chk("lh_data", dv, 32'hFFFF8001);
        do_load(2'b01, 1, 32'h13, 32'h123456F0, 1, rc, sd, se, dv, dc);
        chk("lbu_lane", dv, 32'h000000F0);
        do_load(2'b11, 0, 32'h24, 32'hAAAA8001, 2, rc, sd, se, dv, dc);
        chk("lw_data", dv, 32'hAAAA8001);

        do_load(2'b01, 0, 32'h40, 32'h55, 0, rc, sd, se, dv, dc);
        chk("to_rd_cycles", 32'(rc), TO);
        chk("to_err", 32'(se), 1);
        chk("to_done", 32'(sd), 0);
        chk("to_data_hold", dv, 32'hAAAA8001);
        chk("to_busy_after", 32'(busy), 0);

        do_load(2'b10, 0, 32'h44, 32'h00017FFF, TO, rc, sd, se, dv, dc);
        chk("lastack_done", 32'(sd), 1);
        chk("lastack_err", 32'(se), 0);
        chk("lastack_data", dv, 32'h00007FFF);
        chk("lastack_rd_cycles", 32'(rc), TO);

        do_load(2'b00, 0, 32'h80, 32'hFFFFFFFF, 1, rc, sd, se, dv, dc);
        chk("none_rd_cycles", 32'(rc), 0);
        chk("none_latency", 32'(dc), 1);
        chk("none_data", dv, 32'h0);

        start = 1; ls = 2'b11; addr = 32'h100; uns = 0;
        @(negedge clk);
        start = 1; ls = 2'b01; addr = 32'h200;
        @(negedge clk);
        start = 0;
        chk("busy_start_addr", mem_addr, 32'h100);
        rdata = 32'h89ABCDEF; ack = 1;
        @(negedge clk);
        ack = 0;
        chk("busy_start_done", 32'(done), 1);
        chk("busy_start_data", Data_out, 32'h89ABCDEF);
        @(negedge clk);
        chk("busy_start_idle", 32'(busy), 0);
        @(negedge clk);
        chk("busy_start_not_queued", 32'(busy), 0);

        start = 1; ls = 2'b01; addr = 32'h300;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("abort_mem_rd", 32'(mem_rd), 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_Data_out", Data_out, 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(err), 0);
        @(negedge clk);
        #2 reset_n = 1;
        rdata = 32'hFF; ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_late_done", 32'(done), 0);
            chk("abort_late_data", Data_out, 0);
        end
        ack = 0;

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            reset_n = ($urandom_range(0, 149) != 0);
            start = ($urandom_range(0, 2) == 0);
            ls = 2'($urandom);
            addr = $urandom;
            uns = 1'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            rdata = $urandom;
        end
        @(negedge clk);
        #1;
        reset_n = 1; start = 0; ack = 0;
        repeat (8) @(negedge clk);
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
